// File: rtl/conv_result_packer_if.sv
// Bus bundle for conv_result_packer: the element stream coming down the
// convolution chain plus the output-SRAM write port and status outputs.
interface conv_result_packer_if #(
  parameter int unsigned N  = 9,
  parameter int unsigned AW = 12
);
  // element stream
  logic          go;
  logic [N-1:0]  negative_flags;
  logic [AW-1:0] write_addr_in;
  logic [3:0]    idx_in;
  logic          flush_in;
  // SRAM write port and status
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] words_written;

  // Upstream / testbench side
  modport master (
    output go, negative_flags, write_addr_in, idx_in, flush_in,
    input  mem_we, mem_addr, mem_data, busy, done, words_written
  );

  // Packer side
  modport slave (
    input  go, negative_flags, write_addr_in, idx_in, flush_in,
    output mem_we, mem_addr, mem_data, busy, done, words_written
  );
endinterface

// File: rtl/conv_result_packer.sv
// Terminal stage of the binary convolution pipeline: popcounts each row of
// negative flags, thresholds it to one activation bit, packs 16 bits per word
// and writes full words (or a flushed partial word) to output SRAM.
module conv_result_packer #(
  parameter int unsigned N      = 9,
  parameter int unsigned THRESH = N / 2,
  parameter int unsigned AW     = 12
) (
  input logic                clock,
  input logic                reset,
  conv_result_packer_if.slave bus
);
  localparam int unsigned PW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state, state_nxt;
  logic          accept;
  logic [PW-1:0] pc_in, pc1;
  logic          v1;
  logic [AW-1:0] addr1;
  logic [3:0]    idx1;
  logic [15:0]   buf_q, mask_q, buf_upd, mask_upd;
  logic [AW-1:0] buf_addr;
  logic          wr_full, wr_part, wr_fire;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          mem_we_q, done_q;
  logic [AW-1:0] mem_addr_q, ww_q;
  logic [15:0]   mem_data_q;

  // Elements are ignored while draining so the flush sees a stable buffer
  assign accept = bus.go && (state != S_DRAIN);

  // Popcount of the incoming tap flags
  always_comb begin
    pc_in = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pc_in = pc_in + PW'(bus.negative_flags[i]);
    end
  end

  // Next-state logic: any flush leads to one DRAIN cycle, then back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.flush_in)  state_nxt = S_DRAIN;
        else if (bus.go)   state_nxt = S_FILL;
      end
      S_FILL: begin
        if (bus.flush_in)  state_nxt = S_DRAIN;
      end
      S_DRAIN:             state_nxt = S_IDLE;
      default:             state_nxt = S_IDLE;
    endcase
  end

  // Stage-2 merge of the held element and the resulting write decision.
  // Occupancy comes from mask_upd so an all-zero partial word is still written.
  always_comb begin
    buf_upd  = buf_q;
    mask_upd = mask_q;
    wr_full  = 1'b0;
    if (v1) begin
      buf_upd[idx1]  = (32'(pc1) <= THRESH);
      mask_upd[idx1] = 1'b1;
      wr_full        = (idx1 == 4'd15);
    end
    wr_part = (state == S_DRAIN) && !wr_full && (mask_upd != '0);
    wr_fire = wr_full || wr_part;
    wr_addr = v1 ? addr1 : buf_addr;
    wr_data = buf_upd;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Stage 1: register popcount, address and bit index of an accepted element
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      pc1   <= '0;
      addr1 <= '0;
      idx1  <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        pc1   <= pc_in;
        addr1 <= bus.write_addr_in;
        idx1  <= bus.idx_in;
      end
    end
  end

  // Stage 2: word buffer and written-mask, cleared on any write or drain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_q    <= '0;
      mask_q   <= '0;
      buf_addr <= '0;
    end else begin
      if (wr_fire || (state == S_DRAIN)) begin
        buf_q  <= '0;
        mask_q <= '0;
      end else begin
        buf_q  <= buf_upd;
        mask_q <= mask_upd;
      end
      if (v1) buf_addr <= addr1;
    end
  end

  // SRAM write port, done pulse and write counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
      ww_q       <= '0;
    end else begin
      mem_we_q <= wr_fire;
      done_q   <= (state == S_DRAIN);
      if (wr_fire) begin
        mem_addr_q <= wr_addr;
        mem_data_q <= wr_data;
        ww_q       <= ww_q + 1'b1;
      end
    end
  end

  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_data      = mem_data_q;
  assign bus.done          = done_q;
  assign bus.words_written = ww_q;
  assign bus.busy          = (state != S_IDLE) || v1 || (mask_q != '0);

endmodule
